// File: rtl/change_dispenser.sv
// Change dispenser: splits a Q1 (0.5-yuan unit) amount into 5 / 1 / 0.5 yuan coins,
// ejects them one at a time over a req/ack handshake and keeps the coin-tube inventory.
module change_dispenser #(
  parameter int CNT_W       = 6,
  parameter int INIT_CNT    = 20,
  parameter int CNT_MAX     = 63,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       amount,
  input  logic             coin_in,
  input  logic [1:0]       coin_in_type,
  input  logic             refill,
  output logic             eject_req,
  output logic [1:0]       eject_type,
  input  logic             eject_ack,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [5:0]       remain,
  output logic [2:0]       jam,
  output logic [CNT_W-1:0] cnt_half,
  output logic [CNT_W-1:0] cnt_one,
  output logic [CNT_W-1:0] cnt_five
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EJECT, S_FINISH} state_t;

  state_t                      state_q;
  logic [5:0]                  rem_q;
  logic [TW-1:0]               tmr_q;
  logic                        req_q, busy_q, done_q, short_q;
  logic [5:0]                  remain_q;
  logic [1:0]                  type_q;
  logic [2:0]                  jam_q;
  logic [2:0][CNT_W-1:0]       cnt_q;

  logic                        pick_vld;
  logic [1:0]                  pick_type;
  logic [5:0]                  cur_val;
  logic [2:0]                  type_oh, inc, dec;
  logic                        ack_ev, tmo_ev;

  // Greedy pick: only a coin whose value fits in rem is eligible, so rem never underflows.
  always_comb begin
    pick_vld  = 1'b0;
    pick_type = 2'b00;
    if (rem_q >= 6'd10 && cnt_q[2] != '0 && !jam_q[2]) begin
      pick_vld  = 1'b1;
      pick_type = 2'b10;
    end else if (rem_q >= 6'd2 && cnt_q[1] != '0 && !jam_q[1]) begin
      pick_vld  = 1'b1;
      pick_type = 2'b01;
    end else if (rem_q >= 6'd1 && cnt_q[0] != '0 && !jam_q[0]) begin
      pick_vld  = 1'b1;
      pick_type = 2'b00;
    end
  end

  always_comb begin
    case (type_q)
      2'b10:   cur_val = 6'd10;
      2'b01:   cur_val = 6'd2;
      default: cur_val = 6'd1;
    endcase
  end

  assign type_oh = 3'b001 << type_q;
  assign ack_ev  = req_q && eject_ack;
  assign tmo_ev  = req_q && !eject_ack && (tmr_q == TW'(ACK_TIMEOUT - 1));
  assign inc     = (coin_in && coin_in_type != 2'b11) ? (3'b001 << coin_in_type) : 3'b000;
  assign dec     = ack_ev ? type_oh : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      tmr_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
      remain_q <= '0;
      type_q   <= 2'b00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          rem_q   <= amount;
          short_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_SELECT;
        end
        S_SELECT: if (pick_vld) begin
          type_q  <= pick_type;
          tmr_q   <= '0;
          req_q   <= 1'b1;
          state_q <= S_EJECT;
        end else begin
          // Completion outputs are registered so they appear during the FINISH cycle.
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          short_q  <= (rem_q != '0);
          remain_q <= rem_q;
          state_q  <= S_FINISH;
        end
        S_EJECT: if (ack_ev) begin
          rem_q   <= rem_q - cur_val;
          req_q   <= 1'b0;
          state_q <= S_SELECT;
        end else if (tmo_ev) begin
          req_q   <= 1'b0;
          state_q <= S_SELECT;
        end else begin
          tmr_q <= tmr_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || refill)  jam_q <= '0;
    else if (tmo_ev)    jam_q <= jam_q | type_oh;
  end

  // Coin in and coin out on the same tube in one cycle cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || refill) begin
        cnt_q[i] <= CNT_W'(INIT_CNT);
      end else if (inc[i] && !dec[i]) begin
        if (cnt_q[i] != CNT_W'(CNT_MAX)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end else if (dec[i] && !inc[i] && cnt_q[i] != '0) begin
        cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  assign eject_req  = req_q;
  assign eject_type = type_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign short      = short_q;
  assign remain     = remain_q;
  assign jam        = jam_q;
  assign cnt_half   = cnt_q[0];
  assign cnt_one    = cnt_q[1];
  assign cnt_five   = cnt_q[2];

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequences the physical coin-eject mechanism when the vending FSM reports change or a refund (charge_ind with coin_sum).
- Breaks a Q1 amount (value×2, 0.5-yuan units) into coins greedily: 5-yuan, then 1-yuan, then 0.5-yuan.
- Drives one eject request at a time with a req/ack handshake.
- Tracks a per-denomination coin inventory and reports any shortfall or jammed ejector back to the front-panel logic.

Parameters:
- CNT_W, 6, width of each inventory counter.
- INIT_CNT, 20, inventory value loaded on reset and on refill.
- CNT_MAX, 63, saturation limit for inventory increments.
- ACK_TIMEOUT, 255, cycles eject_req may wait for eject_ack before the ejector is declared jammed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to dispense amount; sampled only in IDLE.
- amount  in  6  Q1 amount to dispense, 0..40.
- coin_in  in  1  one-cycle pulse: accepted coin dropped into the change tubes.
- coin_in_type  in  2  type of that coin: 00=0.5, 01=1, 10=5 yuan; 11 is ignored.
- refill  in  1  one-cycle pulse: all counts to INIT_CNT, jam flags cleared.
- eject_req  out  1  request to eject one coin of eject_type.
- eject_type  out  2  denomination being ejected, same encoding as coin_in_type.
- eject_ack  in  1  ejector done; honoured only while eject_req=1.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- short  out  1  amount could not be fully paid; valid from done until the next start.
- remain  out  6  Q1 amount still unpaid; valid with short.
- jam  out  3  sticky jam flag per ejector, bit0=0.5, bit1=1, bit2=5.
- cnt_half, cnt_one, cnt_five  out  CNT_W  inventory counts.

Behaviour:
- Reset:
  - state IDLE.
  - eject_req, busy, done, short, jam = 0.
  - remain = 0; eject_type = 00.
  - All counts = INIT_CNT.
  - Reset mid-dispense abandons the operation immediately; no done pulse is produced.
- States: IDLE, SELECT, EJECT, FINISH.
- IDLE:
  - On start, latch amount into the rem register and clear short.
  - Enter SELECT; busy=1 from the next cycle.
  - start in any other state is ignored.
- SELECT (one cycle), picks the first match in this order:
  - rem≥10, cnt_five>0, !jam[2] → 5-yuan.
  - rem≥2, cnt_one>0, !jam[1] → 1-yuan.
  - rem≥1, cnt_half>0, !jam[0] → 0.5-yuan.
  - On a match: set eject_type, clear the timeout counter, go to EJECT.
  - No match, or rem=0: go to FINISH.
- EJECT:
  - eject_req=1 and eject_type are held stable until ack or timeout.
  - On eject_ack: decrement the matching count, subtract the denomination value from rem, deassert eject_req in the next cycle, return to SELECT.
  - On timeout (ACK_TIMEOUT cycles without ack): set the matching jam bit, deassert eject_req, return to SELECT. Count and rem are unchanged.
- FINISH (one cycle):
  - done=1; short=(rem≠0); remain=rem; busy drops to 0 in the same cycle.
  - Next state IDLE.
- Latency:
  - amount=0: done 2 cycles after start.
  - Each coin adds 2 cycles plus the ack wait.
- Inventory:
  - coin_in increments the selected count, saturating at CNT_MAX.
  - Simultaneous coin_in and eject_ack on the same denomination leave the count unchanged.
  - refill takes priority over coin_in and eject_ack in the same cycle.
  - refill clears jam but does not disturb an in-progress operation.
- Arithmetic: rem never underflows, because SELECT only chooses a coin whose value is ≤ rem.
- Amounts above 40 are dispensed as given; no clamping is applied.

Test Plan:
- Reset, then start with amount=15 (7.5 yuan), ack each request after 3 cycles → ejects 5, 1, 1, 0.5 in that order; done with short=0; cnt_five=19, cnt_one=18, cnt_half=19.
- refill with cnt_five driven to 0 via ejects, then amount=10 → five 1-yuan ejects; cnt_one=15; short=0.
- Counts one=0, half=0, five=20, amount=3 → no eject_req; done 2 cycles after start; short=1, remain=3.
- Never ack a 5-yuan request with amount=10 → after 255 cycles jam[2]=1; then five 1-yuan ejects complete; short=0.
- coin_in type 01 in the same cycle as eject_ack for type 01 → cnt_one unchanged. Also: start asserted while busy is ignored.
- Assert rst during EJECT → eject_req=0, busy=0 and counts=INIT_CNT next cycle; no done pulse.
